debug_reg_dump: RTL and testbench
=================================

// Module: debug_reg_dump
// PURPOSE
//  Debug-side reader of the decode stage register-file debug port. On request it
//  freezes the pipeline (o_halt) and walks registers 0..N_REGS-1 through the
//  address/data read port. It serializes each 32-bit value as bytes on a
//  valid/ready stream feeding the debug UART transmitter.
//  Sits between the debug unit command decoder and uart_tx; drives i_halt/i_r_addr of the decode stage.
// PARAMETERS
//  NB_DATA  32  register width; must be a multiple of NB_BYTE
//  NB_ADDR  5   register address width
//  N_REGS   32  registers dumped (addresses 0..N_REGS-1), N_REGS <= 2**NB_ADDR
//  NB_BYTE  8   stream byte width
// PORTS
//  i_clk      in   1        clock, all logic on rising edge
//  i_reset    in   1        synchronous reset, active high
//  i_start    in   1        dump request; sampled only in IDLE
//  o_halt     out  1        pipeline freeze to decode stage i_halt
//  o_r_addr   out  NB_ADDR  register address to decode stage i_r_addr
//  i_r_data   in   NB_DATA  register data from decode stage o_r_data (combinational)
//  o_tx_data  out  NB_BYTE  stream byte
//  o_tx_valid out  1        stream byte valid
//  i_tx_ready in   1        sink ready; byte transferred when valid&&ready at clock edge
//  o_busy     out  1        dump in progress (any state but IDLE)
//  o_done     out  1        one-cycle pulse when the last byte has been transferred
// BEHAVIOUR
//  Clocking and reset: one clock (i_clk); synchronous active-high reset (i_reset).
//  Reset values: all outputs 0; FSM=IDLE; reg index=0; byte count=0.
//  All outputs are registered.
//  FSM states:
//   IDLE:    i_start=1 -> FREEZE; set o_halt=1, o_busy=1, index=0.
//   FREEZE:  one cycle for in-flight WB to be blocked -> ADDR.
//   ADDR:    o_r_addr<=index -> CAPTURE.
//   CAPTURE: shift_reg<=i_r_data (one full cycle after address change); byte count=0 -> SEND.
//   SEND:    o_tx_valid=1, o_tx_data=shift_reg[NB_BYTE-1:0] (LSB byte first).
//            On a transfer, shift right by NB_BYTE and increment the byte count.
//            After the NB_DATA/NB_BYTE-th transfer:
//            index==N_REGS-1 -> DONE; otherwise index++ and -> ADDR.
//   DONE:    o_done=1 for one cycle; o_halt=0, o_busy=0 -> IDLE.
//  Latency: i_start to first o_tx_valid = 4 cycles.
//   Per register: 2 cycles + 4 transfers when i_tx_ready is held high.
//  Stream rules: o_tx_data is stable while o_tx_valid=1 and i_tx_ready=0.
//   o_tx_valid never drops without a transfer (reset excepted).
//   o_tx_valid is 0 outside SEND (and CHECK).
//  o_halt: 1 in every state except IDLE. It is deasserted on the same edge that o_done asserts.
//  i_start: ignored while busy; i_start held high in DONE does not restart until IDLE is reached.
//  Index: no wrap-around. The dump ends at N_REGS-1, and o_r_addr holds its last value in IDLE.
//  Reset mid-dump: immediate return to IDLE; o_tx_valid=0 and o_halt=0 on the next edge.
//   A partial dump is abandoned with no o_done.
// CONFIGURATION
//  DBG_DUMP_CHECKSUM_EN defined:
//   - A running XOR of all transferred data bytes is kept (cleared in FREEZE).
//   - After the last register, state CHECK sends that XOR as one extra byte under the same handshake, then -> DONE.
//   - Total bytes = N_REGS*NB_DATA/NB_BYTE + 1.
//  Not defined: no CHECK state and no checksum logic; SEND goes straight to DONE.
// TESTING
//  1 Reg model r[k]=32'h0403_0201+k*32'h0404_0404, ready=1, pulse start
//    -> 128 bytes 01,02,03,04,05,06,... ; o_done pulse; o_halt high throughout.
//  2 Same setup, i_tx_ready toggling randomly
//    -> identical byte sequence; o_tx_data stable while valid&&!ready.
//  3 i_start pulsed again mid-dump and held high during DONE
//    -> no extra bytes; exactly one dump per IDLE-sampled start.
//  4 Reset asserted after byte 37
//    -> next edge o_tx_valid=0, o_halt=0, o_busy=0; no o_done; a fresh start dumps from r0.
//  5 N_REGS=4, r0..r3=0, ready=1 -> 16 zero bytes; o_done 2+4*6=26 cycles after the start edge.
//  6 DBG_DUMP_CHECKSUM_EN, test 1 data
//    -> 129th byte = XOR of the 128 bytes (8'h80); o_done after it.

Source files
------------

// File: rtl/debug_reg_dump_if.sv
// Byte stream from the register dumper to the debug UART transmitter.
// Valid/ready handshake; a byte moves when tx_valid && tx_ready at a rising edge.
interface debug_reg_dump_if #(
    parameter int unsigned NB_BYTE = 8
);
    logic [NB_BYTE-1:0] tx_data;
    logic               tx_valid;
    logic               tx_ready;

    modport master (output tx_data, output tx_valid, input tx_ready);
    modport slave  (input tx_data, input tx_valid, output tx_ready);
endinterface

// File: rtl/debug_reg_dump.sv
// Halts the pipeline, walks the register-file debug port and streams each register LSB byte first.
// Optional DBG_DUMP_CHECKSUM_EN appends one XOR checksum byte after the last register.
module debug_reg_dump #(
    parameter int unsigned NB_DATA = 32,
    parameter int unsigned NB_ADDR = 5,
    parameter int unsigned N_REGS  = 32,
    parameter int unsigned NB_BYTE = 8
) (
    input  logic               i_clk,
    input  logic               i_reset,
    input  logic               i_start,
    output logic               o_halt,
    output logic [NB_ADDR-1:0] o_r_addr,
    input  logic [NB_DATA-1:0] i_r_data,
    debug_reg_dump_if.master   tx,
    output logic               o_busy,
    output logic               o_done
);
    localparam int unsigned N_BYTES = NB_DATA / NB_BYTE;
    localparam int unsigned CNT_W   = (N_BYTES > 1) ? $clog2(N_BYTES) : 1;
    localparam logic [CNT_W-1:0]   LAST_CNT = CNT_W'(N_BYTES - 1);
    localparam logic [NB_ADDR-1:0] LAST_IDX = NB_ADDR'(N_REGS - 1);

    typedef enum logic [2:0] {
        StIdle,
        StFreeze,
        StAddr,
        StCapture,
        StSend,
`ifdef DBG_DUMP_CHECKSUM_EN
        StCheck,
`endif
        StDone
    } state_e;

    state_e             state_q, state_d;
    logic [NB_ADDR-1:0] index_q, index_d;
    logic [NB_ADDR-1:0] addr_q, addr_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [NB_DATA-1:0] shift_q, shift_d;
    logic               valid_q, valid_d;
    logic               halt_q, halt_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic               xfer;
`ifdef DBG_DUMP_CHECKSUM_EN
    logic [NB_BYTE-1:0] csum_q, csum_d;
`endif

    assign xfer = valid_q && tx.tx_ready;

    always_comb begin
        state_d = state_q;
        index_d = index_q;
        addr_d  = addr_q;
        cnt_d   = cnt_q;
        shift_d = shift_q;
        valid_d = valid_q;
        halt_d  = halt_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
`ifdef DBG_DUMP_CHECKSUM_EN
        csum_d  = csum_q;
`endif
        unique case (state_q)
            StIdle: begin
                if (i_start) begin
                    state_d = StFreeze;
                    halt_d  = 1'b1;
                    busy_d  = 1'b1;
                    index_d = '0;
                end
            end
            StFreeze: begin
                // One idle cycle lets any in-flight write-back be blocked by the halt.
                state_d = StAddr;
`ifdef DBG_DUMP_CHECKSUM_EN
                csum_d  = '0;
`endif
            end
            StAddr: begin
                addr_d  = index_q;
                state_d = StCapture;
            end
            StCapture: begin
                shift_d = i_r_data;
                cnt_d   = '0;
                valid_d = 1'b1;
                state_d = StSend;
            end
            StSend: begin
                if (xfer) begin
                    shift_d = shift_q >> NB_BYTE;
                    cnt_d   = cnt_q + 1'b1;
`ifdef DBG_DUMP_CHECKSUM_EN
                    csum_d  = csum_q ^ shift_q[NB_BYTE-1:0];
`endif
                    if (cnt_q == LAST_CNT) begin
                        valid_d = 1'b0;
                        if (index_q == LAST_IDX) begin
`ifdef DBG_DUMP_CHECKSUM_EN
                            valid_d = 1'b1;
                            shift_d = NB_DATA'(csum_q ^ shift_q[NB_BYTE-1:0]);
                            state_d = StCheck;
`else
                            state_d = StDone;
`endif
                        end else begin
                            index_d = index_q + 1'b1;
                            state_d = StAddr;
                        end
                    end
                end
            end
`ifdef DBG_DUMP_CHECKSUM_EN
            StCheck: begin
                if (xfer) begin
                    valid_d = 1'b0;
                    state_d = StDone;
                end
            end
`endif
            StDone: begin
                done_d  = 1'b1;
                halt_d  = 1'b0;
                busy_d  = 1'b0;
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_q <= StIdle;
            index_q <= '0;
            addr_q  <= '0;
            cnt_q   <= '0;
            shift_q <= '0;
            valid_q <= 1'b0;
            halt_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
`ifdef DBG_DUMP_CHECKSUM_EN
            csum_q  <= '0;
`endif
        end else begin
            state_q <= state_d;
            index_q <= index_d;
            addr_q  <= addr_d;
            cnt_q   <= cnt_d;
            shift_q <= shift_d;
            valid_q <= valid_d;
            halt_q  <= halt_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
`ifdef DBG_DUMP_CHECKSUM_EN
            csum_q  <= csum_d;
`endif
        end
    end

    assign o_halt      = halt_q;
    assign o_busy      = busy_q;
    assign o_done      = done_q;
    assign o_r_addr    = addr_q;
    assign tx.tx_valid = valid_q;
    assign tx.tx_data  = shift_q[NB_BYTE-1:0];
endmodule

// File: tb/tb_debug_reg_dump.sv
// Bench for debug_reg_dump: a 32-register dumper with an incrementing register model and a
// 4-register dumper reading zeros, driven from a table of dump scenarios plus a reset-abort case.
module tb_debug_reg_dump;
`ifdef DBG_DUMP_CHECKSUM_EN
    localparam int CSUM = 1;
`else
    localparam int CSUM = 0;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic        start_a, start_b;
    logic        halt_a, busy_a, done_a;
    logic        halt_b, busy_b, done_b;
    logic [4:0]  addr_a, addr_b;
    logic [31:0] rdata_a, rdata_b;

    always #5 clk = ~clk;

    debug_reg_dump_if #(.NB_BYTE(8)) tx_a ();
    debug_reg_dump_if #(.NB_BYTE(8)) tx_b ();

    assign rdata_a = 32'h0403_0201 + 32'(addr_a) * 32'h0404_0404;
    assign rdata_b = '0;

    debug_reg_dump #(.NB_DATA(32), .NB_ADDR(5), .N_REGS(32), .NB_BYTE(8)) dut_a (
        .i_clk(clk), .i_reset(reset), .i_start(start_a), .o_halt(halt_a), .o_r_addr(addr_a),
        .i_r_data(rdata_a), .tx(tx_a), .o_busy(busy_a), .o_done(done_a)
    );

    debug_reg_dump #(.NB_DATA(32), .NB_ADDR(5), .N_REGS(4), .NB_BYTE(8)) dut_b (
        .i_clk(clk), .i_reset(reset), .i_start(start_b), .o_halt(halt_b), .o_r_addr(addr_b),
        .i_r_data(rdata_b), .tx(tx_b), .o_busy(busy_b), .o_done(done_b)
    );

    int checks = 0;
    int failures = 0;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    // Register k holds bytes 4k+1..4k+4 LSB first; checksum is the XOR of all 128 of them.
    function automatic int exp_byte(input int sel, input int j);
        logic [7:0] x;
        if (sel == 1) return 0;
        if (j < 128) return (j + 1) & 8'hff;
        x = 8'h00;
        for (int k = 0; k < 128; k++) x = x ^ 8'(k + 1);
        return int'(x);
    endfunction

    // mode 0: ready=1; mode 1: random ready; mode 2: random ready, start re-raised mid-dump
    // and held through DONE. Observation happens on falling edges.
    task automatic run(input int sel, input int mode, input int exp_bytes, input int exp_done,
                       input int exp_addr);
        int nbytes, ndone, first, done_at, bad_halt, bad_stable, bad_byte;
        logic pv, pr, v, h, b, d, rdy;
        logic [7:0] pd, dat;
        nbytes = 0; ndone = 0; first = -1; done_at = -1;
        bad_halt = 0; bad_stable = 0; bad_byte = 0;
        pv = 1'b0; pr = 1'b0; pd = 8'h00;
        @(negedge clk);
        for (int n = 0; n < 3000; n++) begin
            if (sel == 0) begin
                v = tx_a.tx_valid; dat = tx_a.tx_data; h = halt_a; b = busy_a; d = done_a;
            end else begin
                v = tx_b.tx_valid; dat = tx_b.tx_data; h = halt_b; b = busy_b; d = done_b;
            end
            if (n > 0) begin
                if (h !== b) bad_halt++;
                if (v && !b) bad_halt++;
                if (pv && !pr && (!v || dat !== pd)) bad_stable++;
                if (v && first < 0) first = n;
                if (d) begin
                    ndone++;
                    if (done_at < 0) done_at = n;
                end
            end
            if (mode == 2 && n >= 20 && done_at < 0) begin
                start_a = 1'b1;
                start_b = 1'b1;
            end else begin
                start_a = (n == 0) && (sel == 0);
                start_b = (n == 0) && (sel == 1);
            end
            rdy = (mode == 0) ? 1'b1 : 1'($urandom_range(0, 1));
            tx_a.tx_ready = rdy;
            tx_b.tx_ready = rdy;
            if (v && rdy) begin
                if (int'(dat) != exp_byte(sel, nbytes)) bad_byte++;
                nbytes++;
            end
            pv = v; pr = rdy; pd = dat;
            if (done_at >= 0 && n >= done_at + 8) break;
            @(negedge clk);
        end
        start_a = 1'b0;
        start_b = 1'b0;
        check("done_seen", int'(done_at >= 0), 1);
        check("byte_count", nbytes, exp_bytes);
        check("byte_values_bad", bad_byte, 0);
        check("done_pulses", ndone, 1);
        check("halt_busy_bad", bad_halt, 0);
        check("stream_stable_bad", bad_stable, 0);
        // Valid appears 4 cycles after start is raised (edges 0..3 counted from the start edge).
        check("first_valid_latency", first, 4);
        // done_at is the falling edge after the asserting edge; done_at-1 counts from start edge.
        if (exp_done >= 0) check("done_edge", done_at - 1, exp_done);
        check("idle_r_addr", int'(sel == 0 ? addr_a : addr_b), exp_addr);
        check("idle_busy", int'(sel == 0 ? busy_a : busy_b), 0);
    endtask

    typedef struct {
        int sel;
        int mode;
        int exp_bytes;
        int exp_done;
        int exp_addr;
    } vec_t;

    vec_t vecs[4];

    initial begin
        int nb;
        logic saw_done;
        vecs[0] = '{0, 0, 128 + CSUM, 2 + 32 * 6 + CSUM, 31};
        vecs[1] = '{0, 1, 128 + CSUM, -1, 31};
        vecs[2] = '{0, 2, 128 + CSUM, -1, 31};
        vecs[3] = '{1, 0, 16 + CSUM, 2 + 4 * 6 + CSUM, 3};

        reset = 1'b1;
        start_a = 1'b0;
        start_b = 1'b0;
        tx_a.tx_ready = 1'b1;
        tx_b.tx_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("rst_valid", int'(tx_a.tx_valid), 0);
        check("rst_halt", int'(halt_a), 0);
        check("rst_busy", int'(busy_a), 0);
        check("rst_done", int'(done_a), 0);
        check("rst_addr", int'(addr_a), 0);
        check("rst_b_outputs", int'({tx_b.tx_valid, halt_b, busy_b, done_b}), 0);
        @(negedge clk);
        reset = 1'b0;

        for (int i = 0; i < 4; i++) run(vecs[i].sel, vecs[i].mode, vecs[i].exp_bytes,
                                        vecs[i].exp_done, vecs[i].exp_addr);

        // Abort after the 37th byte: outputs clear on the next edge and no done follows.
        nb = 0;
        saw_done = 1'b0;
        @(negedge clk);
        start_a = 1'b1;
        tx_a.tx_ready = 1'b1;
        for (int n = 0; n < 400 && nb < 37; n++) begin
            @(negedge clk);
            start_a = 1'b0;
            if (tx_a.tx_valid) nb++;
        end
        @(negedge clk);
        check("abort_byte_count", nb, 37);
        reset = 1'b1;
        @(posedge clk);
        #1;
        check("abort_valid", int'(tx_a.tx_valid), 0);
        check("abort_halt", int'(halt_a), 0);
        check("abort_busy", int'(busy_a), 0);
        @(negedge clk);
        reset = 1'b0;
        for (int n = 0; n < 20; n++) begin
            @(negedge clk);
            if (done_a || busy_a) saw_done = 1'b1;
        end
        check("abort_no_done", int'(saw_done), 0);
        run(0, 0, 128 + CSUM, 2 + 32 * 6 + CSUM, 31);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
